// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word type, RAM handshake state and the
// arbiter FSM state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the data and instruction caches. Data wins by
// default; after STARVE_MAX data completions with an instruction fetch pending,
// the instruction side gets one grant.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        memerr
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arbstate_t     r_state;
    arbstate_t     w_next_state;
    logic [SW-1:0] r_starve;
    logic          r_memerr;

    logic          w_dreq;
    logic          w_starved;
    logic          w_dcomplete;
    logic          w_icomplete;
    logic          w_grant_err;

    assign w_dreq      = dREN | dWEN;
    assign w_starved   = iREN && (r_starve == STARVE_LIM);
    // A completion needs the owner to still be requesting; a dropped request is an abort.
    assign w_dcomplete = (r_state == DGRANT) && w_dreq && (ramstate == ACCESS);
    assign w_icomplete = (r_state == IGRANT) && iREN && (ramstate == ACCESS);
    assign w_grant_err = (r_state != IDLE) && (ramstate == ERROR);
    assign memerr      = r_memerr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= '0;
            r_memerr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (!iREN || w_icomplete)
                r_starve <= '0;
            else if (w_dcomplete && (r_starve != STARVE_LIM))
                r_starve <= r_starve + 1'b1;
            if (w_grant_err)
                r_memerr <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_dreq && !w_starved)
                    w_next_state = DGRANT;
                else if (iREN)
                    w_next_state = IGRANT;
            end
            DGRANT: begin
                if (!w_dreq || (ramstate == ACCESS) || (ramstate == ERROR))
                    w_next_state = IDLE;
            end
            IGRANT: begin
                if (!iREN || (ramstate == ACCESS) || (ramstate == ERROR))
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (w_dcomplete) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (w_icomplete) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a word-level memory model and starvation-bound rule.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int SM = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN;
    logic [31:0] daddr, dstore, dload;
    logic        dwait;
    logic        iREN;
    logic [31:0] iaddr, iload;
    logic        iwait;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t   ramstate;
    logic        memerr;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram     [0:15];
    logic [31:0] ref_mem [0:15];

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        iREN = 1'b0; iaddr = '0;
        ramstate = FREE; ramload = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        cyc();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h1234; dstore = 32'h5678;
        iREN = 1'b1; iaddr = 32'h9abc; ramstate = ACCESS; ramload = 32'hCAFEF00D;
        nRST = 1'b0;
        #2;
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL reset_dwait got %0b want 1", dwait); end
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL reset_iwait got %0b want 1", iwait); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN got %0b want 0", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN got %0b want 0", ramWEN); end
        checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr got %h want 0", ramaddr); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore got %h want 0", ramstore); end
        checks++; if (dload !== 32'h0) begin errors++; $display("FAIL reset_dload got %h want 0", dload); end
        checks++; if (iload !== 32'h0) begin errors++; $display("FAIL reset_iload got %h want 0", iload); end
        checks++; if (memerr !== 1'b0) begin errors++; $display("FAIL reset_memerr got %0b want 0", memerr); end
        cyc();
        mid();
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_hold_en got %0b%0b want 00", ramREN, ramWEN); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL reset_hold_dwait got %0b want 1", dwait); end
        idle_inputs();
        cyc();
        nRST = 1'b1;
    endtask

    task automatic test_data_read();
        do_reset();
        dREN = 1'b1; daddr = 32'h40;
        mid();
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rd_grant_latency ramREN got %0b want 0", ramREN); end
        cyc(); ramstate = BUSY;
        mid();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rd_ramREN got %0b want 1", ramREN); end
        checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rd_ramWEN got %0b want 0", ramWEN); end
        checks++; if (ramaddr !== 32'h40) begin errors++; $display("FAIL rd_ramaddr got %h want 40", ramaddr); end
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rd_busy1_dwait got %0b want 1", dwait); end
        cyc(); ramstate = BUSY;
        mid();
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rd_busy2_dwait got %0b want 1", dwait); end
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF;
        mid();
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL rd_done_dwait got %0b want 0", dwait); end
        checks++; if (dload !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_dload got %h want deadbeef", dload); end
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL rd_iwait got %0b want 1", iwait); end
        cyc(); dREN = 1'b0; ramstate = FREE; ramload = 32'h0;
        mid();
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rd_after_dwait got %0b want 1", dwait); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rd_after_ramREN got %0b want 0", ramREN); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        dREN = 1'b1; daddr = 32'h80; dstore = 32'hAAAA5555;
        iREN = 1'b1; iaddr = 32'h1000;
        cyc(); ramstate = ACCESS; ramload = 32'h11112222;
        mid();
        checks++; if (ramaddr !== 32'h80) begin errors++; $display("FAIL sim_first_addr got %h want 80", ramaddr); end
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL sim_dwait got %0b want 0", dwait); end
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL sim_iwait_held got %0b want 1", iwait); end
        checks++; if (iload !== 32'h0) begin errors++; $display("FAIL sim_iload_zero got %h want 0", iload); end
        cyc(); dREN = 1'b0; ramstate = FREE;
        mid();
        checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL sim_arb_cycle ramREN %0b iwait %0b want 0 1", ramREN, iwait); end
        cyc(); ramstate = ACCESS; ramload = 32'h33334444;
        mid();
        checks++; if (ramaddr !== 32'h1000) begin errors++; $display("FAIL sim_iaddr got %h want 1000", ramaddr); end
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL sim_ien got %0b%0b want 10", ramREN, ramWEN); end
        checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL sim_istore got %h want 0", ramstore); end
        checks++; if (iwait !== 1'b0) begin errors++; $display("FAIL sim_idone got %0b want 0", iwait); end
        checks++; if (iload !== 32'h33334444) begin errors++; $display("FAIL sim_iload got %h want 33334444", iload); end
        checks++; if (dwait !== 1'b1 || dload !== 32'h0) begin errors++; $display("FAIL sim_dside got %0b %h want 1 0", dwait, dload); end
        cyc(); iREN = 1'b0; ramstate = FREE;
    endtask

    task automatic test_starvation();
        int seq[$];
        do_reset();
        dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h300;
        ramstate = ACCESS; ramload = 32'h77;
        for (int c = 0; c < 60 && seq.size() < 10; c++) begin
            cyc();
            mid();
            if (!dwait) seq.push_back(1);
            else if (!iwait) seq.push_back(2);
        end
        checks++;
        if (seq.size() != 10) begin errors++; $display("FAIL starve_count got %0d want 10", seq.size()); end
        for (int k = 0; k < seq.size(); k++) begin
            checks++;
            if (seq[k] != (((k % (SM + 1)) == SM) ? 2 : 1)) begin
                errors++;
                $display("FAIL starve_order idx %0d got %0d want %0d", k, seq[k], ((k % (SM + 1)) == SM) ? 2 : 1);
            end
        end
        cyc(); idle_inputs();
    endtask

    task automatic test_write();
        do_reset();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h5;
        cyc(); ramstate = BUSY;
        mid();
        checks++; if (ramWEN !== 1'b1) begin errors++; $display("FAIL wr_ramWEN got %0b want 1", ramWEN); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL wr_ramREN got %0b want 0", ramREN); end
        checks++; if (ramaddr !== 32'h3100) begin errors++; $display("FAIL wr_ramaddr got %h want 3100", ramaddr); end
        checks++; if (ramstore !== 32'h5) begin errors++; $display("FAIL wr_ramstore got %h want 5", ramstore); end
        cyc(); ramstate = ACCESS;
        mid();
        checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL wr_done got %0b want 0", dwait); end
        cyc(); idle_inputs();
    endtask

    task automatic test_abort();
        do_reset();
        dREN = 1'b1; daddr = 32'h8;
        cyc(); ramstate = BUSY;
        mid();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL abort_granted got %0b want 1", ramREN); end
        cyc(); dREN = 1'b0; ramstate = ACCESS; ramload = 32'h99;
        mid();
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL abort_no_done got %0b want 1", dwait); end
        cyc();
        mid();
        checks++; if (ramaddr !== 32'h0 || dwait !== 1'b1) begin errors++; $display("FAIL abort_idle addr %h dwait %0b want 0 1", ramaddr, dwait); end
        cyc(); idle_inputs();
    endtask

    task automatic test_error();
        do_reset();
        iREN = 1'b1; iaddr = 32'h44;
        cyc(); ramstate = ERROR;
        mid();
        checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL err_iwait got %0b want 1", iwait); end
        cyc(); iREN = 1'b0; ramstate = FREE;
        mid();
        checks++; if (memerr !== 1'b1) begin errors++; $display("FAIL err_memerr got %0b want 1", memerr); end
        checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL err_idle got ramREN %0b want 0", ramREN); end
        cyc(); dREN = 1'b1; ramstate = ACCESS;
        cyc(); dREN = 1'b0;
        mid();
        checks++; if (memerr !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", memerr); end
        cyc(); nRST = 1'b0;
        #1;
        checks++; if (memerr !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", memerr); end
        cyc(); nRST = 1'b1; idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        dREN = 1'b1; daddr = 32'h40;
        cyc(); ramstate = BUSY;
        mid();
        checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL rstmid_granted got %0b want 1", ramREN); end
        cyc(); ramstate = ACCESS; ramload = 32'hDEADBEEF; nRST = 1'b0;
        #1;
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rstmid_dwait got %0b want 1", dwait); end
        checks++; if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rstmid_ram got %0b %h want 0 0", ramREN, ramaddr); end
        checks++; if (dload !== 32'h0) begin errors++; $display("FAIL rstmid_dload got %h want 0", dload); end
        cyc(); nRST = 1'b1;
        mid();
        checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL rstmid_after got %0b want 1", dwait); end
        cyc(); idle_inputs();
    endtask

    task automatic test_random();
        bit d_active = 1'b0, d_done = 1'b0, i_active = 1'b0, i_done = 1'b0;
        bit acc_open = 1'b0;
        int busy_left = 0, d_age = 0, i_age = 0, streak = 0, n_d = 0, n_i = 0;
        logic [31:0] v;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            v = $urandom;
            ram[k] = v;
            ref_mem[k] = v;
        end
        for (int c = 0; c < 1500; c++) begin
            cyc();
            if (d_done) begin dREN = 1'b0; dWEN = 1'b0; d_active = 1'b0; d_done = 1'b0; end
            if (i_done) begin iREN = 1'b0; i_active = 1'b0; i_done = 1'b0; end
            if (!d_active && $urandom_range(0, 2) == 0) begin
                d_active = 1'b1; d_age = 0;
                dWEN = ($urandom_range(0, 2) == 0);
                dREN = dWEN ? ($urandom_range(0, 1) != 0) : 1'b1;
                daddr = 32'($urandom_range(0, 15)) << 2;
                dstore = $urandom;
            end
            if (!i_active && $urandom_range(0, 2) == 0) begin
                i_active = 1'b1; i_age = 0;
                iREN = 1'b1;
                iaddr = 32'($urandom_range(0, 15)) << 2;
            end
            #1;
            // Behavioural RAM: random BUSY latency, then one ACCESS cycle
            if (ramREN || ramWEN) begin
                if (!acc_open) begin acc_open = 1'b1; busy_left = $urandom_range(0, 3); end
                if (busy_left > 0) begin
                    ramstate = BUSY; busy_left--; ramload = $urandom;
                end else begin
                    ramstate = ACCESS; acc_open = 1'b0;
                    if (ramWEN) begin ram[ramaddr[5:2]] = ramstore; ramload = $urandom; end
                    else ramload = ram[ramaddr[5:2]];
                end
            end else begin
                acc_open = 1'b0;
                ramstate = ($urandom_range(0, 1) != 0) ? FREE : BUSY;
                ramload = $urandom;
            end
            mid();
            checks++; if (!dwait && !iwait) begin errors++; $display("FAIL rnd_both_done cycle %0d", c); end
            if (!dwait) begin
                checks++;
                if (!(dREN || dWEN)) begin errors++; $display("FAIL rnd_spurious_d cycle %0d", c); end
                if (dWEN) ref_mem[daddr[5:2]] = dstore;
                else begin
                    checks++;
                    if (dload !== ref_mem[daddr[5:2]]) begin errors++; $display("FAIL rnd_dload addr %h got %h want %h", daddr, dload, ref_mem[daddr[5:2]]); end
                end
                if (iREN) streak++;
                d_done = 1'b1; n_d++;
            end
            if (!iwait) begin
                checks++;
                if (!iREN) begin errors++; $display("FAIL rnd_spurious_i cycle %0d", c); end
                checks++;
                if (iload !== ref_mem[iaddr[5:2]]) begin errors++; $display("FAIL rnd_iload addr %h got %h want %h", iaddr, iload, ref_mem[iaddr[5:2]]); end
                streak = 0;
                i_done = 1'b1; n_i++;
            end
            if (!iREN) streak = 0;
            checks++; if (streak > SM) begin errors++; $display("FAIL rnd_starve streak got %0d want <= %0d", streak, SM); end
            checks++; if (memerr !== 1'b0) begin errors++; $display("FAIL rnd_memerr got %0b want 0", memerr); end
            if (d_active && !d_done) d_age++;
            if (i_active && !i_done) i_age++;
            checks++;
            if (d_age > 64 || i_age > 64) begin
                errors++;
                $display("FAIL rnd_timeout d_age %0d i_age %0d want <= 64", d_age, i_age);
                d_age = 0; i_age = 0;
            end
        end
        checks++; if (n_d < 50) begin errors++; $display("FAIL rnd_d_progress got %0d want >= 50", n_d); end
        checks++; if (n_i < 50) begin errors++; $display("FAIL rnd_i_progress got %0d want >= 50", n_i); end
        cyc(); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b1;
        test_reset();
        test_data_read();
        test_simultaneous();
        test_starvation();
        test_write();
        test_abort();
        test_error();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, number of consecutive data grants allowed while iREN is pending before the instruction side is granted once.
REQ-002 CLK  in  1  system clock; all state updates on the rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 dREN  in  1  data-cache read request.
REQ-005 dWEN  in  1  data-cache write request.
REQ-006 daddr  in  32  data-cache word address.
REQ-007 dstore  in  32  data-cache write data.
REQ-008 dwait  out  1  high while the data-side access is not complete; low only in the completing cycle.
REQ-009 dload  out  32  data-side read data; valid when dwait is low and dREN is high.
REQ-010 iREN  in  1  instruction-cache read request.
REQ-011 iaddr  in  32  instruction-cache word address.
REQ-012 iwait  out  1  high while the instruction-side access is not complete.
REQ-013 iload  out  32  instruction-side read data; valid when iwait is low.
REQ-014 ramREN / ramWEN  out  1 each  RAM read and write enables.
REQ-015 ramaddr / ramstore  out  32 each  RAM address and write data.
REQ-016 ramload  in  32  RAM read data.
REQ-017 ramstate  in  ramstate_t (2)  FREE, BUSY, ACCESS, ERROR.
REQ-018 memerr  out  1  sticky error flag.

Function
REQ-019 The FSM SHALL have states IDLE, DGRANT, and IGRANT.
REQ-020 In IDLE, no RAM enable is driven, and dwait and iwait are both 1.
REQ-021 IDLE -> DGRANT when (dREN|dWEN) and not starved; IDLE -> IGRANT when iREN and (no data request, or starve count == STARVE_MAX).
REQ-022 Grant is registered: a request first seen in cycle N drives RAM no earlier than cycle N+1.
REQ-023 DGRANT: ramaddr = daddr, ramstore = dstore, ramWEN = dWEN, ramREN = dREN & ~dWEN; a write takes priority if both are asserted.
REQ-024 IGRANT: ramaddr = iaddr, ramREN = 1, ramWEN = 0, ramstore = 0.
REQ-025 A granted side's wait goes low combinationally in the cycle ramstate == ACCESS, with load = ramload; the FSM then returns to IDLE and re-arbitrates.
REQ-026 The non-granted side's wait stays 1, and its load is 0.
REQ-027 If the granted requester deasserts all its enables before ACCESS, the FSM returns to IDLE next cycle with no completion.
REQ-028 ramstate == ERROR in a grant state: memerr is set to 1 (sticky until reset), wait stays 1, and the FSM returns to IDLE.
REQ-029 Starve counter (width clog2(STARVE_MAX+1)):
  - increments on each DGRANT completion while iREN is high, saturating at STARVE_MAX;
  - clears on IGRANT completion or when iREN is low.
REQ-030 BUSY/FREE in a grant state: hold the grant and hold the RAM outputs stable.
REQ-031 Back-to-back data words (two-word block fill or writeback) each cost one arbitration cycle plus RAM latency; the data side wins again unless starved.

Reset
REQ-032 While nRST == 0, the following values SHALL hold:
  - state IDLE and starve count 0;
  - memerr 0;
  - dwait = iwait = 1;
  - ramREN = ramWEN = 0;
  - ramaddr = ramstore = dload = iload = 0.
REQ-033 Reset mid-access SHALL abort immediately, and no completion is reported for the aborted access.

Structure
REQ-034 ramstate_t and word_t come from cpu_types_pkg; the arbiter state enum is added to cpu_types_pkg as arbstate_t.
REQ-035 The block is a single module with no sub-module; the combinational output decode and the registered FSM/counter are kept separate.

Verification
REQ-036 Data read at daddr 0x40, RAM returning 0xDEADBEEF after 2 BUSY cycles -> ramREN=1 from cycle 1; dwait low exactly one cycle with dload=0xDEADBEEF.
REQ-037 dREN and iREN asserted simultaneously -> DGRANT first; iwait is held 1 until the data completes; IGRANT follows.
REQ-038 Continuous dREN+iREN with STARVE_MAX=4 -> 4 data completions, then 1 instruction completion, repeating.
REQ-039 dWEN with daddr 0x3100 and dstore 0x5 -> ramWEN=1, ramaddr=0x3100, ramstore=0x5; ramREN=0.
REQ-040 ramstate=ERROR during IGRANT -> memerr=1 persists, iwait stays 1, FSM is in IDLE next cycle; nRST clears memerr.
REQ-041 nRST pulsed low while in DGRANT -> all outputs are at reset values in the same cycle; no dwait-low pulse occurs.
